// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin share of the vga_adapter pixel port among NUM_REQ drawing engines,
// with per-requester lock for whole primitives and a stall timeout that forcibly releases the lock.
module vga_plot_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int X_W          = 9,
    parameter int Y_W          = 8,
    parameter int C_W          = 3,
    parameter int LOCK_TIMEOUT = 1023
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state;
    logic [1:0]       last, owner, pick, sel, idx;
    logic             pick_ok, accept, sel_lock;
    logic [CNT_W-1:0] stall_cnt;

    // descending scan so the nearest requester after last is written last and wins
    always_comb begin
        pick    = last;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NUM_REQ);
            if (|(req_valid & (NUM_REQ'(1) << idx))) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sel       = (state == LOCKED) ? owner : pick;
        req_ready = (reset || (state == ARB && !pick_ok)) ? '0 : NUM_REQ'(1) << sel;
        accept    = |(req_valid & req_ready);
        sel_lock  = |(req_lock & (NUM_REQ'(1) << sel));
    end

    assign busy = (state == LOCKED);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= ARB;
            last        <= 2'(NUM_REQ - 1);
            owner       <= '0;
            stall_cnt   <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            vga_plot    <= accept;
            timeout_err <= 1'b0;
            if (accept) begin
                vga_x      <= req_x[sel*X_W +: X_W];
                vga_y      <= req_y[sel*Y_W +: Y_W];
                vga_colour <= req_colour[sel*C_W +: C_W];
                last       <= sel;
                grant_id   <= sel;
            end
            if (state == ARB) begin
                stall_cnt <= '0;
                if (accept && sel_lock) begin
                    state <= LOCKED;
                    owner <= sel;
                end
            end else if (accept || !sel_lock) begin
                stall_cnt <= '0;
                if (!sel_lock)
                    state <= ARB;
            end else if (stall_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                state       <= ARB;
                timeout_err <= 1'b1;
                stall_cnt   <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between up to four pixel-producing engines: line drawers, screen clear, cursor. Arbitration is round-robin with an optional per-requester lock that holds ownership for a whole primitive (e.g. one line), plus a lock-stall timeout. The block sits between the drawing FSMs and `vga_adapter`, and registers every accepted pixel onto the adapter port.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..4.
- `X_W`, 9: x coordinate width (320 columns).
- `Y_W`, 8: y coordinate width (240 rows).
- `C_W`, 3: colour width.
- `LOCK_TIMEOUT`, 1023: maximum idle cycles a locked owner may hold the port without presenting a pixel.

- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i presents a pixel.
- `req_lock`  in  NUM_REQ  requester i asks to keep ownership after the current pixel.
- `req_x`  in  NUM_REQ*X_W  packed x coordinates; requester i occupies bits [i*X_W +: X_W].
- `req_y`  in  NUM_REQ*Y_W  packed y coordinates, same packing.
- `req_colour`  in  NUM_REQ*C_W  packed colours, same packing.
- `req_ready`  out  NUM_REQ  combinational; the pixel from requester i is accepted on a cycle where both `req_valid[i]` and `req_ready[i]` are high.
- `vga_x`  out  X_W  registered x to the adapter.
- `vga_y`  out  Y_W  registered y to the adapter.
- `vga_colour`  out  C_W  registered colour to the adapter.
- `vga_plot`  out  1  registered one-cycle write strobe.
- `grant_id`  out  2  current or last owner index.
- `busy`  out  1  high while in the LOCKED state.
- `timeout_err`  out  1  one-cycle pulse when a lock is forcibly released.

## Operation
- State machine has two states, ARB and LOCKED. Reset state is ARB.
- ARB state:
  - `pick` is the first i with `req_valid[i]`=1, searching upward from `last+1` and wrapping modulo NUM_REQ.
  - `req_ready[pick]`=1; every other `req_ready` bit is 0. If no requester is valid, all `req_ready` bits are 0.
  - On accept: `last` <= pick and `grant_id` <= pick. If `req_lock[pick]`=1, go to LOCKED with owner = pick; otherwise stay in ARB.
- LOCKED state:
  - `req_ready[owner]`=1 whether or not the owner is valid. All other `req_ready` bits are 0.
  - An accepted pixel with `req_lock[owner]`=0 returns to ARB after that pixel.
  - `req_valid[owner]`=0 together with `req_lock[owner]`=0 returns to ARB with no pixel written.
  - `req_valid[owner]`=0 with `req_lock[owner]`=1 increments the stall counter. Any accepted pixel clears the counter.
  - When the counter reaches LOCK_TIMEOUT: go to ARB, pulse `timeout_err` for 1 cycle, clear the counter. The timed-out owner keeps `last`, so it gets lowest priority in the next arbitration.
- Datapath: on every accept, the selected requester's x/y/colour are registered into `vga_x`/`vga_y`/`vga_colour` and `vga_plot` is set to 1. On cycles with no accept, `vga_plot`=0 and x/y/colour hold their values.
- No width conversion is done. Range checking of coordinates (x<320, y<240) is the requester's responsibility; values are passed through unchanged.
- Reset values:
  - All outputs are 0.
  - `last` = NUM_REQ-1, so requester 0 has first priority.
  - Stall counter = 0.
- Reset in mid-operation: asserting `reset` abandons LOCKED and drops any pending pixel. `vga_plot` is 0 on the cycle after the reset edge.

## Timing
- Accept is zero-wait: `req_ready` depends combinationally on the state and on `req_valid`/`last`. There is no combinational path from `req_x`/`req_y`/`req_colour` to `req_ready`.
- Latency is 1 cycle: a pixel accepted at edge N appears with `vga_plot`=1 in the cycle after edge N.
- Throughput is one pixel per cycle, sustained, including back-to-back pixels from different requesters in ARB.
- Arbitration and lock changes take effect on the edge of the accepting cycle. The new owner's first pixel can be accepted in the very next cycle.
- Simultaneous events:
  - Timeout on the same cycle the owner raises valid: the accept wins, no timeout occurs, and the counter clears.
  - `reset` together with any request: reset wins.
- `timeout_err` is high exactly for the cycle after the counter reaches LOCK_TIMEOUT.

## Test plan
- **Reset:** hold `reset` 2 cycles with all `req_valid`=1 -> all outputs 0 during reset. On the first cycle after reset, `req_ready`=4'b0001. On the next cycle, `vga_plot`=1 with req0's pixel.
- **Round-robin fairness:** all 4 requesters valid continuously, `req_lock`=0, each presenting its own fixed pixel (req0 at x=10, y=5, colour 3'b101; req1..req3 distinct) -> grants follow 0,1,2,3,0,... and `vga_plot` stays high every cycle with matching x/y/colour.
- **Lock burst:** req1 streams 100 pixels (x=0..99, y=50) with `req_lock`=1, last pixel with lock=0; req2 stays valid throughout -> req2 gets no `req_ready` until the cycle after req1's 100th accept. `busy` is high for the whole burst.
- **Lock stall:** req3 is locked and drops valid for 20 cycles with lock=1, then resumes -> no `timeout_err`, the counter clears, and req3 retains ownership.
- **Lock timeout:** LOCK_TIMEOUT=8 (override). req0 locks and then stalls with req1 valid -> `timeout_err` pulses 8 cycles into the stall, and req1 is accepted on the following cycle.
- **Reset mid-lock:** req2 is mid-burst and `reset` asserts for 1 cycle -> state returns to ARB, `vga_plot`=0, and `req_ready`=4'b0001 if req0 is valid afterwards.
